// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between requester 0 (execute stage)
// and requester 1 (branch/compare helper) with round-robin arbitration.
// Latency: rsp_valid rises ALU_LAT cycles after the accept edge; one op in flight.
// Backpressure: req*_ready only while idle; rsp_* held stable until rsp_ready.
// Ports: clk, rst (async, active high); req0_*/req1_* valid/ready op channels
// (ctrl, a, b, shamt, shctrl); alu_* drive/sample the external ALU; rsp_* tagged
// result channel (id, data, zero, flag) with valid/ready.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctrl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_shctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctrl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_shctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  alu_shamt,
  output logic        alu_shctrl,
  input  logic [31:0] alu_o_p,
  input  logic        alu_zero,
  input  logic        alu_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_flag
);

  localparam logic [1:0] CNT_LAST = 2'(ALU_LAT - 1);
  localparam logic [3:0] CTRL_IDLE = 4'b1111;  // ALU default path, o_p = 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        capture;
  logic        last_grant;
  logic        grant0, grant1;
  logic        take0, take1;

  logic [3:0]  op_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_shamt;
  logic        op_shctrl;
  logic        op_id;

  always_ff @(posedge clk) begin
    assert (ALU_LAT >= 1 && ALU_LAT <= 4)
      else $error("alu_arbiter: ALU_LAT must be 1..4");
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Gated by rst so no handshake is offered while reset is held, even though
  // the state register already reads IDLE asynchronously.
  assign req0_ready = (state == IDLE) && grant0 && !rst;
  assign req1_ready = (state == IDLE) && grant1 && !rst;
  assign take0      = req0_valid && req0_ready;
  assign take1      = req1_valid && req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (take0 || take1) begin
          state_nxt = EXEC;
          cnt_nxt   = 2'd0;
        end
      end
      EXEC: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == CNT_LAST) begin
          state_nxt = RESP;
          cnt_nxt   = 2'd0;
          capture   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ctrl    <= 4'd0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_shamt   <= 5'd0;
      op_shctrl  <= 1'b0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;  // requester 0 wins the first tie
      rsp_id     <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_flag   <= 1'b0;
    end else begin
      if (take0) begin
        op_ctrl    <= req0_ctrl;
        op_a       <= req0_a;
        op_b       <= req0_b;
        op_shamt   <= req0_shamt;
        op_shctrl  <= req0_shctrl;
        op_id      <= 1'b0;
        last_grant <= 1'b0;
      end else if (take1) begin
        op_ctrl    <= req1_ctrl;
        op_a       <= req1_a;
        op_b       <= req1_b;
        op_shamt   <= req1_shamt;
        op_shctrl  <= req1_shctrl;
        op_id      <= 1'b1;
        last_grant <= 1'b1;
      end
      if (capture) begin
        rsp_data <= alu_o_p;
        rsp_zero <= alu_zero;
        rsp_flag <= alu_flag;
        rsp_id   <= op_id;
      end
    end
  end

  // ALU inputs come only from the latched op so requester activity never
  // toggles the ALU; while idle the opcode is parked on the default path.
  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign alu_shamt  = op_shamt;
  assign alu_shctrl = op_shctrl;
  assign alu_ctrl   = (state == IDLE) ? CTRL_IDLE : op_ctrl;
  assign rsp_valid  = (state == RESP);

endmodule
